// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int ITER_COUNT = 32;
    localparam int LATENCY    = 37;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEG_A,
        ST_NEG_B,
        ST_ITER,
        ST_FIX_LO,
        ST_FIX_HI
    } state_e;

endpackage

// File: rtl/AddSubX32.sv
// 32-bit adder/subtractor shared by every arithmetic step of the HI/LO unit.
module AddSubX32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Sub,
    output logic [31:0] S
);

    assign S = Sub ? (A - B) : (A + B);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; every
// add/subtract goes through the single AddSubX32 instance.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WriteHi,
    input  logic        WriteLo,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        DivZero
);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, mag_a_q, mag_b_q, phi_q, plo_q;
    logic [4:0]  cnt_q;
    logic        neg_lo_q, neg_hi_q, dz_q, cin_q;

    logic [31:0] add_a, add_b, add_s, r_sh;
    logic        add_sub, carry, borrow;
    logic        sa_d, sb_d, dz_d, neg_lo_d, neg_hi_d;

    AddSubX32 u_addsub (
        .A   (add_a),
        .B   (add_b),
        .Sub (add_sub),
        .S   (add_s)
    );

    assign carry  = add_s < add_a;
    assign borrow = add_a < add_b;
    assign r_sh   = {phi_q[30:0], plo_q[31]};

    // Sign bookkeeping decided once at acceptance; divide-by-zero suppresses fix-up.
    always_comb begin
        sa_d     = Op[0] & A[31];
        sb_d     = Op[0] & B[31];
        dz_d     = Op[1] & (B == 32'd0);
        neg_lo_d = (sa_d ^ sb_d) & ~dz_d;
        neg_hi_d = Op[1] ? sa_d : (sa_d ^ sb_d);
    end

    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_sub = 1'b0;
        case (state_q)
            ST_NEG_A: begin
                if (op_q[0] && a_q[31]) begin
                    add_b   = a_q;
                    add_sub = 1'b1;
                end else begin
                    add_a = a_q;
                end
            end
            ST_NEG_B: begin
                if (op_q[0] && b_q[31]) begin
                    add_b   = b_q;
                    add_sub = 1'b1;
                end else begin
                    add_a = b_q;
                end
            end
            ST_ITER: begin
                if (op_q[1]) begin
                    add_a   = r_sh;
                    add_b   = mag_b_q;
                    add_sub = 1'b1;
                end else begin
                    add_a = phi_q;
                    add_b = mag_a_q;
                end
            end
            ST_FIX_LO: begin
                if (neg_lo_q) begin
                    add_b   = plo_q;
                    add_sub = 1'b1;
                end else begin
                    add_a = plo_q;
                end
            end
            ST_FIX_HI: begin
                // A zero divisor reports the captured dividend unchanged in HI.
                if (dz_q) begin
                    add_a = a_q;
                end else if (neg_hi_q) begin
                    add_a = ~phi_q;
                    add_b = {31'd0, cin_q};
                end else begin
                    add_a = phi_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            cnt_q    <= 5'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            cin_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= 32'd0;
            Lo       <= 32'd0;
            DivZero  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        op_q     <= Op;
                        a_q      <= A;
                        b_q      <= B;
                        dz_q     <= dz_d;
                        neg_lo_q <= neg_lo_d;
                        neg_hi_q <= neg_hi_d;
                        Busy     <= 1'b1;
                        state_q  <= ST_NEG_A;
                    end else begin
                        if (WriteHi) Hi <= WData;
                        if (WriteLo) Lo <= WData;
                    end
                end
                ST_NEG_A: begin
                    mag_a_q <= add_s;
                    state_q <= ST_NEG_B;
                end
                ST_NEG_B: begin
                    mag_b_q <= add_s;
                    phi_q   <= 32'd0;
                    plo_q   <= op_q[1] ? mag_a_q : add_s;
                    cnt_q   <= 5'd0;
                    state_q <= ST_ITER;
                end
                ST_ITER: begin
                    if (op_q[1]) begin
                        // Restoring step: an overflowing partial remainder always subtracts.
                        if (phi_q[31] || !borrow) begin
                            phi_q <= add_s;
                            plo_q <= {plo_q[30:0], 1'b1};
                        end else begin
                            phi_q <= r_sh;
                            plo_q <= {plo_q[30:0], 1'b0};
                        end
                    end else if (plo_q[0]) begin
                        phi_q <= {carry, add_s[31:1]};
                        plo_q <= {add_s[0], plo_q[31:1]};
                    end else begin
                        phi_q <= {1'b0, phi_q[31:1]};
                        plo_q <= {phi_q[0], plo_q[31:1]};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER_COUNT - 1)) state_q <= ST_FIX_LO;
                end
                ST_FIX_LO: begin
                    plo_q   <= add_s;
                    cin_q   <= op_q[1] | (plo_q == 32'd0);
                    state_q <= ST_FIX_HI;
                end
                ST_FIX_HI: begin
                    Hi      <= add_s;
                    Lo      <= plo_q;
                    DivZero <= dz_q;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model plus directed vectors.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst, Start, WriteHi, WriteLo;
    logic [1:0]  Op;
    logic [31:0] A, B, WData;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    muldiv_seq dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .WriteHi(WriteHi), .WriteLo(WriteLo), .WData(WData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result {divzero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned pu;
        longint          ps;
        int              q, r;
        case (op)
            OP_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                return {1'b0, pu};
            end
            OP_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, ps};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {1'b0, r, q};
            end
        endcase
    endfunction

    // Cycle-level model: result appears with Done 37 cycles after acceptance.
    int          m_cnt = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_done = 0, m_dz = 0;
    logic [64:0] r_res = 0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_cnt  <= 0;
            m_hi   <= 0;
            m_lo   <= 0;
            m_done <= 0;
            m_dz   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_dz   <= r_res[64];
                    m_hi   <= r_res[63:32];
                    m_lo   <= r_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (Start) begin
                r_res <= ref_fn(Op, A, B);
                m_cnt <= 36;
            end else begin
                if (WriteHi) m_hi <= WData;
                if (WriteLo) m_lo <= WData;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model_busy", {31'd0, Busy}, {31'd0, m_cnt != 0});
            chk("model_done", {31'd0, Done}, {31'd0, m_done});
            chk("model_hi", Hi, m_hi);
            chk("model_lo", Lo, m_lo);
            chk("model_dz", {31'd0, DivZero}, {31'd0, m_dz});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0; A = 32'hA5A5A5A5; B = 32'h5A5A5A5A; Op = ~op;
    endtask

    // Called in cycle cyc0 after acceptance; Done must land in cycle 37.
    task automatic wait_done(input string nm, input int cyc0, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic edz);
        int cyc, busy_n;
        cyc = cyc0;
        busy_n = 0;
        while (!Done && cyc < 100) begin
            if (Busy) busy_n++;
            tick();
            cyc++;
        end
        if (!Done) begin
            chk({nm, "_timeout"}, {31'd0, Done}, 32'd1);
        end else begin
            chk({nm, "_latency"}, cyc, 37);
            chk({nm, "_busycycles"}, busy_n, 37 - cyc0);
            chk({nm, "_hi"}, Hi, ehi);
            chk({nm, "_lo"}, Lo, elo);
            chk({nm, "_dz"}, {31'd0, DivZero}, {31'd0, edz});
        end
    endtask

    initial begin
        int done_seen;
        Rst = 1'b1; Start = 1'b0; Op = 2'd0; A = 0; B = 0;
        WriteHi = 1'b0; WriteLo = 1'b0; WData = 0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_hi", Hi, 32'd0);
        chk("rst_lo", Lo, 32'd0);
        chk("rst_dz", {31'd0, DivZero}, 32'd0);
        tick();

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max", 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        tick();
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_done("mult_neg", 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        issue(OP_MULT, 32'h80000000, 32'h80000000);
        wait_done("mult_minmin", 1, 32'h40000000, 32'd0, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done("divu_b2b", 1, 32'd1, 32'd3, 1'b0);
        tick();
        issue(OP_DIVU, 32'h12345678, 32'd0);
        wait_done("divu_zero", 1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_done("multu_dzclr", 1, 32'd0, 32'd6, 1'b0);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 1, 32'd0, 32'h80000000, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF0, 32'd0);
        wait_done("div_zero_neg", 1, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
        issue(OP_MULT, 32'd7, 32'hFFFFFFFD);
        wait_done("mult_mixed", 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        issue(OP_DIV, 32'd100, 32'hFFFFFFF9);
        wait_done("div_negdivisor", 1, 32'd2, 32'hFFFFFFF2, 1'b0);
        tick();

        WriteHi = 1'b1; WData = 32'hDEADBEEF;
        tick();
        WriteHi = 1'b0;
        chk("mthi_hi", Hi, 32'hDEADBEEF);
        chk("mthi_lo_kept", Lo, 32'hFFFFFFF2);
        WriteLo = 1'b1; WData = 32'hCAFEF00D;
        tick();
        WriteLo = 1'b0;
        chk("mtlo_lo", Lo, 32'hCAFEF00D);

        issue(OP_MULTU, 32'd5, 32'd7);
        tick();
        WriteLo = 1'b1; WData = 32'h11111111;
        tick();
        WriteLo = 1'b0;
        chk("mtlo_busy_dropped", Lo, 32'hCAFEF00D);
        wait_done("multu_5x7", 3, 32'd0, 32'd35, 1'b0);

        WriteLo = 1'b1; WData = 32'h22222222;
        issue(OP_MULTU, 32'd1, 32'd1);
        WriteLo = 1'b0;
        chk("mtlo_start_dropped", Lo, 32'd35);
        wait_done("multu_1x1", 1, 32'd0, 32'd1, 1'b0);
        tick();

        issue(OP_MULTU, 32'h10, 32'h20);
        repeat (4) tick();
        Start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd3;
        tick();
        Start = 1'b0;
        wait_done("start_ignored", 6, 32'd0, 32'h200, 1'b0);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (Done) done_seen++;
        end
        chk("no_queued_start", done_seen, 0);

        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (19) tick();
        Rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, Busy}, 32'd0);
        chk("async_rst_done", {31'd0, Done}, 32'd0);
        chk("async_rst_hi", Hi, 32'd0);
        chk("async_rst_lo", Lo, 32'd0);
        tick();
        tick();
        Rst = 1'b0;
        done_seen = 0;
        repeat (60) begin
            tick();
            if (Done) done_seen++;
        end
        chk("no_done_after_rst", done_seen, 0);
        chk("idle_after_rst", {31'd0, Busy}, 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle HI/LO unit for MULT, MULTU, DIV and DIVU. It sequences a single shared AddSubX32 instance through sign preparation, 32 shift-add or restoring-subtract iterations, and sign fix-up. It sits beside the ALU in the EX stage and owns the architectural Hi/Lo registers, including MTHI/MTLO writes. Pipeline control stalls on Busy.

Parameters:
ITER_COUNT, 32, iteration cycles; localparam, not overridable (datapath fixed at 32 bits).
LATENCY, 37, cycles from the Start-accepting edge to Done high; localparam, informative.

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-high reset
Start  input  1  launch operation; accepted only when Busy=0
Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
A  input  32  multiplicand / dividend
B  input  32  multiplier / divisor
WriteHi  input  1  MTHI write strobe
WriteLo  input  1  MTLO write strobe
WData  input  32  MTHI/MTLO data
Busy  output  1  operation in flight
Done  output  1  one-cycle pulse; Hi/Lo hold the new result
Hi  output  32  HI register (product high word / remainder)
Lo  output  32  LO register (product low word / quotient)
DivZero  output  1  last completed divide had B=0; cleared at the next Done

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE; Busy=0, Done=0, Hi=0, Lo=0, DivZero=0; all working registers cleared.
- Registered outputs. Hi and Lo keep their last value until the next Done or an MTHI/MTLO write.
- States: IDLE -> NEG_A -> NEG_B -> ITER (x32) -> FIX_LO -> FIX_HI -> IDLE.
- Start is sampled at edge 0. Busy is high in cycles 1..36.
- At the end of cycle 36, Hi and Lo load the result. In cycle 37, Done=1 and Busy=0.
- A Start in cycle 37 is accepted, so back-to-back issue is possible.
- Start while Busy=1 is ignored. Op, A and B are captured only at acceptance.
- All adds and subtracts use the one AddSubX32 instance; its S output is the only arithmetic result.
  - Carry out of an add: S < A_in (unsigned compare).
  - Borrow out of a subtract: A_in < B_in (unsigned compare).
- NEG_A / NEG_B: for a signed op with a negative operand, the magnitude register gets 0 - x (A_in=0, B_in=x, Sub=1). Otherwise it gets x + 0. Both states always run, so latency is fixed.
- ITER, multiply: {P_hi, P_lo} starts at {0, |B|}.
  - If P_lo[0]=1: {c, sum} = P_hi + |A|, then {P_hi, P_lo} = {c, sum, P_lo} >> 1.
  - If P_lo[0]=0: shift right by 1 with 0 entering.
- ITER, divide (restoring): {R, Q} starts at {0, |A|}.
  - R' = {R[30:0], Q[31]}, t = R[31].
  - Compute D = R' - |B|.
  - If t=1 or there is no borrow: R = D and the new Q bit is 1. Otherwise R = R' and the new Q bit is 0.
  - Q shifts left by 1 with the new Q bit entering at bit 0.
- Sign correction, multiply: negate the 64-bit result when sign(A) != sign(B).
- Sign correction, divide: negate the quotient (Lo) when signs differ; negate the remainder (Hi) when the dividend is negative.
- FIX_LO: Lo = 0 - lo when negating, else lo + 0.
- FIX_HI: Hi = ~hi + cin when negating, else hi + 0.
  - cin = 1 for divide.
  - cin = (pre-negation lo == 0) for multiply.
- Divide by zero (either signedness): Lo = 0xFFFFFFFF, Hi = A as captured, DivZero=1. Latency is unchanged.
- 0x80000000 / 0xFFFFFFFF (DIV): Lo = 0x80000000, Hi = 0. No exception is raised.
- MTHI/MTLO:
  - Honoured only when Busy=0 and Start=0; Hi or Lo loads WData on the next edge.
  - If Start and WriteHi/WriteLo occur in the same cycle, Start wins and the write is dropped.
  - Writes while Busy are dropped.

Decomposition:
- Shared package muldiv_pkg holds:
  - the Op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state encoding;
  - ITER_COUNT and LATENCY.
- No new sub-module. The only child is the existing AddSubX32, instantiated exactly once.

Test Plan:
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> Done exactly 37 cycles after the Start edge; Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for 36 cycles.
- MULT, A=0xFFFFFFFE, B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. Then MULT, A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- DIV, A=0xFFFFFFF9, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU, A=7, B=2 issued in the Done cycle -> Lo=3, Hi=1, DivZero=0.
- DIVU, A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, DivZero=1. A following MULTU 2*3 -> DivZero=0, Lo=6, Hi=0.
- Start a MULTU, pulse Start again 5 cycles later with different operands, then assert Rst at cycle 20:
  - the second Start is ignored;
  - on Rst, Busy, Done, Hi and Lo all go to 0 without waiting for an edge;
  - no Done appears afterwards.
- While idle, WriteHi with WData=0xDEADBEEF -> Hi=0xDEADBEEF next cycle. WriteLo while Busy -> Lo unchanged until Done. WriteLo together with Start -> dropped.
